wb_periph_ctrl: RTL

Wishbone transaction controller between the Caravel management-SoC slave port and the user-area peripherals (PTC/PWM, I2C, RTC, PID). It decodes the 4 KB page, registers and sequences one transaction at a time to the selected peripheral, and returns a registered ack and read data. It also terminates accesses to unmapped pages and to peripherals that never ack, so a hung peripheral cannot stall the management core.

---
 rtl/wb_periph_ctrl_if.sv | 24 ++
 rtl/wb_periph_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/wb_periph_ctrl_if.sv
// Wishbone bus between the management-SoC master port
// and the peripheral transaction controller.
interface wb_periph_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i,
        output wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
        input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_periph_ctrl.sv
// Single-outstanding Wishbone transaction controller with page
// decode, per-slot strobes, unmapped/timeout termination.
module wb_periph_ctrl #(
    parameter int          NSLV      = 5,
    parameter logic [19:0] BASE_PAGE = 20'h30001,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    wb_periph_ctrl_if.slave    wbs,
    output logic               s_cyc_o,
    output logic [NSLV-1:0]    s_stb_o,
    output logic               s_we_o,
    output logic [3:0]         s_sel_o,
    output logic [31:0]        s_adr_o,
    output logic [31:0]        s_dat_o,
    input  logic [NSLV-1:0]    s_ack_i,
    input  logic [32*NSLV-1:0] s_dat_i,
    output logic               busy_o,
    output logic               err_o,
    output logic [7:0]         to_cnt_o
);
    typedef enum logic [1:0] {
        S_IDLE, S_WAIT, S_RESP, S_DONE
    } state_t;

    state_t          r_state;
    logic [2:0]      r_slot;
    logic [7:0]      r_timer;
    logic            r_ack;
    logic [31:0]     r_rdat;
    logic            r_err;
    logic [7:0]      r_to_cnt;
    logic            r_cyc;
    logic [NSLV-1:0] r_stb;
    logic            r_we;
    logic [3:0]      r_sel;
    logic [31:0]     r_adr;
    logic [31:0]     r_wdat;

    logic [19:0]     w_page;
    logic            w_hit;
    logic [2:0]      w_slot;
    logic            w_ack;
    logic [31:0]     w_sdat;

    // Pages below the base wrap to large offsets and miss.
    assign w_page = wbs.wbs_adr_i[31:12] - BASE_PAGE;
    assign w_hit  = w_page < 20'(NSLV);
    assign w_slot = w_page[2:0];
    assign w_ack  = |(s_ack_i & r_stb);

    always_comb begin
        w_sdat = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (r_slot == 3'(k)) w_sdat = s_dat_i[32*k +: 32];
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_rdat;
    assign s_cyc_o       = r_cyc;
    assign s_stb_o       = r_stb;
    assign s_we_o        = r_we;
    assign s_sel_o       = r_sel;
    assign s_adr_o       = r_adr;
    assign s_dat_o       = r_wdat;
    assign busy_o        = (r_state != S_IDLE);
    assign err_o         = r_err;
    assign to_cnt_o      = r_to_cnt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state  <= S_IDLE;
            r_slot   <= '0;
            r_timer  <= '0;
            r_ack    <= 1'b0;
            r_rdat   <= '0;
            r_err    <= 1'b0;
            r_to_cnt <= '0;
            r_cyc    <= 1'b0;
            r_stb    <= '0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_adr    <= '0;
            r_wdat   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
                        r_we   <= wbs.wbs_we_i;
                        r_sel  <= wbs.wbs_sel_i;
                        r_adr  <= wbs.wbs_adr_i;
                        r_wdat <= wbs.wbs_dat_i;
                        r_slot <= w_slot;
                        if (w_hit) begin
                            r_cyc   <= 1'b1;
                            r_stb   <= NSLV'(1) << w_slot;
                            r_timer <= '0;
                            r_state <= S_WAIT;
                        end else begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (!wbs.wbs_cyc_i) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_ack) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= '0;
                        r_rdat  <= w_sdat;
                        r_ack   <= 1'b1;
                        r_state <= S_RESP;
                    end else if (r_timer == TIMEOUT) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= '0;
                        r_rdat  <= {24'hDEAD00, 5'b0, r_slot};
                        r_ack   <= 1'b1;
                        r_err   <= 1'b1;
                        if (r_to_cnt != 8'hFF) r_to_cnt <= r_to_cnt + 8'd1;
                        r_state <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_RESP: begin
                    // Unmapped pages arrive here with no ack yet.
                    if (r_ack) begin
                        r_ack   <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_ack  <= 1'b1;
                        r_err  <= 1'b1;
                        r_rdat <= 32'hDEAD_DEAD;
                    end
                end
                S_DONE: begin
                    if (!wbs.wbs_stb_i) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
